// File: rtl/maxpool_seq_ctrl_pkg.sv
// Shared constants for the MaxPooling sequencer: FSM encodings and window geometry.
// MINV is declared in each module because its width follows the WIDTH parameter.
package maxpool_seq_ctrl_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_COLLECT = 3'd1;
  localparam logic [2:0] ST_BURST   = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_EMIT    = 3'd4;
  localparam logic [2:0] ST_FIN     = 3'd5;

  // Index of the final slot of a window, and the fixed burst length.
  localparam logic [1:0] WIN3_LAST = 2'd2;
  localparam logic [1:0] WIN2_LAST = 2'd1;
  localparam int         BURST_LEN = 3;

  function automatic logic [1:0] win_last(input logic s3);
    return s3 ? WIN3_LAST : WIN2_LAST;
  endfunction

endpackage

// File: rtl/maxpool_seq_ctrl_win_buf.sv
// Three-entry pooling window buffer: indexed writes, clear-to-MINV, and a burst read pointer.
module maxpool_seq_ctrl_win_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_adv,
  output logic [1:0]       wr_idx,
  output logic [WIDTH-1:0] rd_data
);

  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH-1:0] slot0_q, slot0_d;
  logic [WIDTH-1:0] slot1_q, slot1_d;
  logic [WIDTH-1:0] slot2_q, slot2_d;
  logic [1:0]       wr_idx_q, wr_idx_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;

  // Next-state for slots and pointers; clear wins over write and advance.
  always_comb begin
    slot0_d  = slot0_q;
    slot1_d  = slot1_q;
    slot2_d  = slot2_q;
    wr_idx_d = wr_idx_q;
    rd_ptr_d = rd_ptr_q;
    if (clr) begin
      slot0_d  = MINV;
      slot1_d  = MINV;
      slot2_d  = MINV;
      wr_idx_d = 2'd0;
      rd_ptr_d = 2'd0;
    end else begin
      if (wr_en) begin
        case (wr_idx_q)
          2'd0:    slot0_d = wr_data;
          2'd1:    slot1_d = wr_data;
          2'd2:    slot2_d = wr_data;
          default: slot2_d = slot2_q;
        endcase
        wr_idx_d = wr_idx_q + 2'd1;
      end else begin
        wr_idx_d = wr_idx_q;
      end
      if (rd_adv) begin
        rd_ptr_d = rd_ptr_q + 2'd1;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // Slot and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q  <= MINV;
      slot1_q  <= MINV;
      slot2_q  <= MINV;
      wr_idx_q <= 2'd0;
      rd_ptr_q <= 2'd0;
    end else begin
      slot0_q  <= slot0_d;
      slot1_q  <= slot1_d;
      slot2_q  <= slot2_d;
      wr_idx_q <= wr_idx_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Burst read mux; past the last slot it yields MINV.
  always_comb begin
    case (rd_ptr_q)
      2'd0:    rd_data = slot0_q;
      2'd1:    rd_data = slot1_q;
      2'd2:    rd_data = slot2_q;
      default: rd_data = MINV;
    endcase
  end

  assign wr_idx = wr_idx_q;

endmodule

// File: rtl/maxpool_seq_ctrl.sv
// Streams one feature-map channel through MaxPooling: buffers each window, bursts it
// without stalls, waits out the pool latency and presents the result on a valid/ready port.
module maxpool_seq_ctrl
  import maxpool_seq_ctrl_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int LEN_W    = 12,
  parameter int PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             cfg_s3,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic [WIDTH-1:0] pool_din,
  output logic             pool_s3,
  input  logic [WIDTH-1:0] pool_dout,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] MINV      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam int               CNT_W     = 8;
  localparam logic [CNT_W-1:0] BURST_END = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] WAIT_END  = CNT_W'(PIPE_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic             s3_q, s3_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_last_q, out_last_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             buf_clr, buf_wr, buf_adv;
  logic [1:0]       buf_idx;
  logic [WIDTH-1:0] buf_rd;
  logic             in_hs;

  assign in_hs = in_valid & in_ready_q;

  maxpool_seq_ctrl_win_buf #(.WIDTH(WIDTH)) u_win_buf (
    .clk     (clk),
    .rst     (rst),
    .clr     (buf_clr),
    .wr_en   (buf_wr),
    .wr_data (in_data),
    .rd_adv  (buf_adv),
    .wr_idx  (buf_idx),
    .rd_data (buf_rd)
  );

  // Sequencer next-state and datapath control.
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    s3_d       = s3_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    out_last_d = out_last_q;
    buf_clr    = 1'b0;
    buf_wr     = 1'b0;
    buf_adv    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_len != {LEN_W{1'b0}}) begin
            state_d = ST_COLLECT;
            rem_d   = cfg_len;
            s3_d    = cfg_s3;
            buf_clr = 1'b1;
          end else begin
            state_d = ST_FIN;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_COLLECT: begin
        if (in_hs) begin
          buf_wr = 1'b1;
          rem_d  = rem_q - LEN_ONE;
          // A short final window bursts as soon as the channel runs out.
          if ((buf_idx == win_last(s3_q)) || (rem_q == LEN_ONE)) begin
            state_d = ST_BURST;
            cnt_d   = {CNT_W{1'b0}};
          end else begin
            state_d = ST_COLLECT;
          end
        end else begin
          state_d = ST_COLLECT;
        end
      end
      ST_BURST: begin
        buf_adv = 1'b1;
        if (cnt_q == BURST_END) begin
          state_d = ST_WAIT;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_END) begin
          state_d    = ST_EMIT;
          out_data_d = pool_dout;
          out_last_d = (rem_q == {LEN_W{1'b0}});
          cnt_d      = {CNT_W{1'b0}};
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          out_data_d = {WIDTH{1'b0}};
          out_last_d = 1'b0;
          if (out_last_q) begin
            state_d = ST_FIN;
          end else begin
            state_d = ST_COLLECT;
            buf_clr = 1'b1;
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
        s3_d    = 1'b0;
        rem_d   = {LEN_W{1'b0}};
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Handshake and status flags follow the state being entered.
  always_comb begin
    in_ready_d  = (state_d == ST_COLLECT);
    out_valid_d = (state_d == ST_EMIT);
    busy_d      = (state_d != ST_IDLE);
    done_d      = (state_q == ST_FIN);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= {LEN_W{1'b0}};
      s3_q        <= 1'b0;
      cnt_q       <= {CNT_W{1'b0}};
      out_data_q  <= {WIDTH{1'b0}};
      out_last_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      s3_q        <= s3_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pool_din  = (state_q == ST_BURST) ? buf_rd : MINV;
  assign pool_s3   = s3_q;
  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_maxpool_seq_ctrl.sv
// Directed bench for maxpool_seq_ctrl with a behavioural MaxPooling model on the pool port.
module tb_maxpool_seq_ctrl;

  localparam int WIDTH    = 32;
  localparam int LEN_W    = 12;
  localparam int PIPE_LAT = 2;
  localparam logic signed [WIDTH-1:0] MINV = 32'sh80000000;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    start = 1'b0;
  logic [LEN_W-1:0]        cfg_len = 12'd0;
  logic                    cfg_s3 = 1'b0;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic signed [WIDTH-1:0] in_data = 32'sd0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic signed [WIDTH-1:0] out_data;
  logic                    out_last;
  logic signed [WIDTH-1:0] pool_din;
  logic                    pool_s3;
  logic signed [WIDTH-1:0] pool_dout;
  logic                    busy;
  logic                    done;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  maxpool_seq_ctrl #(.WIDTH(WIDTH), .LEN_W(LEN_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_s3    (cfg_s3),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .pool_din  (pool_din),
    .pool_s3   (pool_s3),
    .pool_dout (pool_dout),
    .busy      (busy),
    .done      (done)
  );

  // MaxPooling: 3-deep shift register, S3 takes all taps, S2 the two oldest; 2-cycle latency.
  logic signed [WIDTH-1:0] mp_r0, mp_r1, mp_r2;

  function automatic logic signed [WIDTH-1:0] smax(input logic signed [WIDTH-1:0] a,
                                                   input logic signed [WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always @(posedge clk) begin
    mp_r0     <= pool_din;
    mp_r1     <= mp_r0;
    mp_r2     <= mp_r1;
    pool_dout <= pool_s3 ? smax(smax(mp_r0, mp_r1), mp_r2) : smax(mp_r1, mp_r2);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [WIDTH-1:0] obs,
                     input logic signed [WIDTH-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk1({tag, "_in_ready"}, in_ready, 1'b0);
    chk1({tag, "_out_valid"}, out_valid, 1'b0);
    chk({tag, "_out_data"}, out_data, 32'sd0);
    chk1({tag, "_out_last"}, out_last, 1'b0);
    chk({tag, "_pool_din"}, pool_din, MINV);
    chk1({tag, "_pool_s3"}, pool_s3, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
  endtask

  task automatic start_ch(input logic [LEN_W-1:0] len, input logic s3);
    cfg_len = len;
    cfg_s3  = s3;
    start   = 1'b1;
    step();
    start   = 1'b0;
  endtask

  task automatic send(input logic signed [WIDTH-1:0] d);
    int n = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    chk1("send_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic signed [WIDTH-1:0] exp,
                      input logic exp_last, input int stall);
    int n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    chk1({tag, "_valid"}, out_valid, 1'b1);
    chk({tag, "_data"}, out_data, exp);
    chk1({tag, "_last"}, out_last, exp_last);
    for (int i = 0; i < stall; i++) begin
      step();
      chk1({tag, "_hold_valid"}, out_valid, 1'b1);
      chk({tag, "_hold_data"}, out_data, exp);
      chk1({tag, "_hold_in_ready"}, in_ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic check_done(input string tag);
    chk1({tag, "_fin_done"}, done, 1'b0);
    chk1({tag, "_fin_busy"}, busy, 1'b1);
    chk1({tag, "_fin_valid"}, out_valid, 1'b0);
    step();
    chk1({tag, "_done"}, done, 1'b1);
    chk1({tag, "_busy_low"}, busy, 1'b0);
    step();
    chk1({tag, "_done_pulse"}, done, 1'b0);
  endtask

  task automatic run_s1(input string tag);
    logic signed [WIDTH-1:0] burst_exp [4];
    burst_exp[0] = 32'sd5;
    burst_exp[1] = -32'sd3;
    burst_exp[2] = 32'sd9;
    burst_exp[3] = MINV;
    out_ready = 1'b1;
    start_ch(12'd6, 1'b1);
    chk1({tag, "_busy"}, busy, 1'b1);
    chk1({tag, "_collect_ready"}, in_ready, 1'b1);
    chk1({tag, "_pool_s3"}, pool_s3, 1'b1);
    send(32'sd5);
    send(-32'sd3);
    send(32'sd9);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) step();
      if (k < 4) chk({tag, "_burst_din"}, pool_din, burst_exp[k]);
      chk1({tag, "_lat_valid"}, out_valid, 1'b0);
      chk1({tag, "_lat_in_ready"}, in_ready, 1'b0);
    end
    step();
    chk1({tag, "_lat5_valid"}, out_valid, 1'b1);
    recv({tag, "_r0"}, 32'sd9, 1'b0, 0);
    out_ready = 1'b1;
    send(32'sd2);
    send(32'sd8);
    send(32'sd1);
    recv({tag, "_r1"}, 32'sd8, 1'b1, 0);
    check_done(tag);
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    check_idle("reset");

    run_s1("s1");

    start_ch(12'd5, 1'b0);
    chk1("s2_pool_s3", pool_s3, 1'b0);
    send(-32'sd7);
    send(-32'sd2);
    recv("s2_r0", -32'sd2, 1'b0, 0);
    send(32'sd4);
    send(32'sd4);
    recv("s2_r1", 32'sd4, 1'b0, 0);
    send(-32'sd100);
    recv("s2_r2", -32'sd100, 1'b1, 0);
    check_done("s2");

    start_ch(12'd6, 1'b1);
    send(32'sd5);
    step();
    step();
    chk1("s3_stall_ready", in_ready, 1'b1);
    send(-32'sd3);
    send(32'sd9);
    step();
    chk1("s3_burst_ready", in_ready, 1'b0);
    recv("s3_r0", 32'sd9, 1'b0, 3);
    send(32'sd2);
    send(32'sd8);
    send(32'sd1);
    recv("s3_r1", 32'sd8, 1'b1, 0);
    check_done("s3");

    start_ch(12'd3, 1'b1);
    send(32'sh80000001);
    send(-32'sd5);
    send(32'sh80000000);
    recv("s4_r0", -32'sd5, 1'b1, 0);
    check_done("s4");

    start_ch(12'd0, 1'b1);
    chk1("s5_valid", out_valid, 1'b0);
    chk1("s5_in_ready", in_ready, 1'b0);
    check_done("s5");
    start_ch(12'd2, 1'b0);
    send(32'sd3);
    start_ch(12'd0, 1'b1);
    chk1("s5_ign_ready", in_ready, 1'b1);
    chk1("s5_ign_busy", busy, 1'b1);
    chk1("s5_ign_s3", pool_s3, 1'b0);
    send(-32'sd1);
    recv("s5_r0", 32'sd3, 1'b1, 0);
    check_done("s5b");

    start_ch(12'd6, 1'b1);
    send(32'sd5);
    send(-32'sd3);
    send(32'sd9);
    step();
    step();
    step();
    rst = 1'b1;
    step();
    check_idle("s6_rst");
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk1("s6_no_valid", out_valid, 1'b0);
      chk1("s6_no_done", done, 1'b0);
    end
    run_s1("s6");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
